// File: rtl/control_unit.sv
// Multicycle MIPS-style control FSM: FETCH -> DECODE -> EXEC, with optional exception states under CU_EXCEPTION_EN.
// Latency: 3 clocks per instruction (4 when an exception state is entered); outputs are Moore-decoded from state/opcode/funct.
// Backpressure: none; the datapath holds instruction stable, and reset (active-low, async) forces FETCH and zeroes all controls.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        zero_flag,
    input  logic        overflow,
    input  logic        div_zero,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] address,
    output logic [3:0]  alu_control,
    output logic        alu_zero,
    output logic        alu_overflow,
    output logic        reg_dst,
    output logic        jump,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [4:0]  current_state
);

    localparam logic [4:0] S_FETCH   = 5'd0;
    localparam logic [4:0] S_DECODE  = 5'd1;
    localparam logic [4:0] S_EXEC    = 5'd2;
    localparam logic [4:0] S_EXC_OVF = 5'd3;
    localparam logic [4:0] S_EXC_DIV = 5'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_XCHG = 6'h05;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    logic [4:0] state_q;
    logic [4:0] state_d;
    logic       is_rtype;
    logic       is_arith;
    logic       ovf_fault;

    logic       d_reg_dst, d_jump, d_branch, d_mem_read, d_mem_to_reg;
    logic       d_mem_write, d_alu_src, d_reg_write, d_pc_write, d_pc_write_cond;
    logic [1:0] d_alu_op;
    logic [1:0] d_pc_source;
    logic [3:0] d_alu_control;

    assign opcode    = instruction[31:26];
    assign rs        = instruction[25:21];
    assign rt        = instruction[20:16];
    assign rd        = instruction[15:11];
    assign shamt     = instruction[10:6];
    assign funct     = instruction[5:0];
    assign immediate = instruction[15:0];
    assign address   = instruction[25:0];

    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_arith  = (is_rtype && (funct == F_ADD || funct == F_SUB)) || (opcode == OP_ADDI);
    assign ovf_fault = overflow && is_arith;

    assign current_state = state_q;
    assign alu_zero      = zero_flag;
    assign alu_overflow  = ovf_fault && (state_q == S_EXEC);

`ifdef CU_EXCEPTION_EN
    logic div_fault;
    assign div_fault = div_zero && is_rtype && (funct == F_DIV);
`else
    logic unused_div_zero;
    assign unused_div_zero = div_zero;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
`ifdef CU_EXCEPTION_EN
                if (ovf_fault) begin
                    state_d = S_EXC_OVF;
                end else if (div_fault) begin
                    state_d = S_EXC_DIV;
                end
`endif
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        d_reg_dst       = 1'b0;
        d_jump          = 1'b0;
        d_branch        = 1'b0;
        d_mem_read      = 1'b0;
        d_mem_to_reg    = 1'b0;
        d_mem_write     = 1'b0;
        d_alu_src       = 1'b0;
        d_reg_write     = 1'b0;
        d_pc_write      = 1'b0;
        d_pc_write_cond = 1'b0;
        d_alu_op        = 2'b00;
        d_pc_source     = 2'b00;
        d_alu_control   = ALU_NONE;
        case (state_q)
            S_FETCH: begin
                d_mem_read    = 1'b1;
                d_pc_write    = 1'b1;
                d_alu_control = ALU_ADD;
            end
            S_DECODE: d_alu_control = ALU_ADD;
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        d_alu_op = 2'b10;
                        case (funct)
                            F_ADD:  begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_control = ALU_ADD; end
                            F_SUB:  begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_control = ALU_SUB; end
                            F_AND:  begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_control = ALU_AND; end
                            F_SLT:  begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_control = ALU_SLT; end
                            F_SLL:  begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_control = ALU_SLL; end
                            F_SRA:  begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_control = ALU_SRA; end
                            F_MFHI, F_MFLO: begin d_reg_dst = 1'b1; d_reg_write = 1'b1; end
                            // The datapath swaps both registers; reg_dst stays 0 so rt is the first target.
                            F_XCHG: d_reg_write = 1'b1;
                            F_JR: begin
                                d_jump      = 1'b1;
                                d_pc_write  = 1'b1;
                                d_pc_source = 2'b10;
                            end
                            // HI/LO are written by the multiply/divide unit, not the register file.
                            F_MULT, F_DIV: ;
                            default: ;
                        endcase
                    end
                    OP_ADDI: begin
                        d_alu_src     = 1'b1;
                        d_reg_write   = 1'b1;
                        d_alu_control = ALU_ADD;
                    end
                    OP_LW: begin
                        d_alu_src     = 1'b1;
                        d_mem_read    = 1'b1;
                        d_mem_to_reg  = 1'b1;
                        d_reg_write   = 1'b1;
                        d_alu_control = ALU_ADD;
                    end
                    OP_SW: begin
                        d_alu_src     = 1'b1;
                        d_mem_write   = 1'b1;
                        d_alu_control = ALU_ADD;
                    end
                    OP_BEQ: begin
                        d_branch        = 1'b1;
                        d_pc_write_cond = 1'b1;
                        d_alu_op        = 2'b01;
                        d_pc_source     = 2'b01;
                        d_alu_control   = ALU_SUB;
                    end
                    OP_J: begin
                        d_jump      = 1'b1;
                        d_pc_write  = 1'b1;
                        d_pc_source = 2'b10;
                    end
                    default: ;
                endcase
`ifdef CU_EXCEPTION_EN
                // A faulting add/sub/addi must not commit its result.
                if (ovf_fault) begin
                    d_reg_write = 1'b0;
                end
`endif
            end
            S_EXC_OVF, S_EXC_DIV: begin
                d_pc_write  = 1'b1;
                d_pc_source = 2'b11;
            end
            default: ;
        endcase
    end

    // Reset gates every strobe combinationally so an aborted instruction cannot write.
    assign {reg_dst, jump, branch, mem_read, mem_to_reg,
            mem_write, alu_src, reg_write, pc_write, pc_write_cond} =
        reset ? {d_reg_dst, d_jump, d_branch, d_mem_read, d_mem_to_reg,
                 d_mem_write, d_alu_src, d_reg_write, d_pc_write, d_pc_write_cond} : 10'b0;
    assign alu_op      = reset ? d_alu_op      : 2'b00;
    assign pc_source   = reset ? d_pc_source   : 2'b00;
    assign alu_control = reset ? d_alu_control : ALU_NONE;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        zero_flag, overflow, div_zero;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, current_state;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [3:0]  alu_control;
    logic        alu_zero, alu_overflow;
    logic        reg_dst, jump, branch, mem_read, mem_to_reg;
    logic        mem_write, alu_src, reg_write, pc_write, pc_write_cond;
    logic [1:0]  alu_op, pc_source;

    control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .zero_flag(zero_flag), .overflow(overflow), .div_zero(div_zero),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .address(address),
        .alu_control(alu_control), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .reg_dst(reg_dst), .jump(jump), .branch(branch), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_op(alu_op), .pc_source(pc_source), .current_state(current_state)
    );

    always #5 clk = ~clk;

`ifdef CU_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  st;
        logic [9:0]  ctl;   // reg_dst,jump,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,pc_write,pc_write_cond
        logic [1:0]  aop;
        logic [1:0]  psrc;
        logic [3:0]  actl;
        logic        ovf;
        logic        zf;
        logic        chk;
        logic [31:0] word;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic exp_t mk(input logic [4:0] st, input logic [9:0] ctl, input logic [1:0] aop,
                                input logic [1:0] psrc, input logic [3:0] actl, input logic ovf);
        exp_t r;
        r.st = st; r.ctl = ctl; r.aop = aop; r.psrc = psrc; r.actl = actl; r.ovf = ovf;
        r.zf = 1'b0; r.chk = 1'b0; r.word = 32'h0;
        return r;
    endfunction

    exp_t rst_e, fetch_e, decode_e, exc_ovf_e, exc_div_e, none_e;
    initial begin
        rst_e     = mk(5'd0, 10'b0000000000, 2'b00, 2'b00, 4'b1111, 1'b0);
        fetch_e   = mk(5'd0, 10'b0001000010, 2'b00, 2'b00, 4'b0010, 1'b0);
        decode_e  = mk(5'd1, 10'b0000000000, 2'b00, 2'b00, 4'b0010, 1'b0);
        exc_ovf_e = mk(5'd3, 10'b0000000010, 2'b00, 2'b11, 4'b1111, 1'b0);
        exc_div_e = mk(5'd4, 10'b0000000010, 2'b00, 2'b11, 4'b1111, 1'b0);
        none_e    = mk(5'd0, 10'b0000000000, 2'b00, 2'b00, 4'b0000, 1'b0);
    end

    task automatic push(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_instr(input string nm, input logic [31:0] instr, input logic ov, input logic dz,
                             input logic zf, input exp_t ex, input bit has_exc, input exp_t exc);
        exp_t e;
        instruction = instr; overflow = ov; div_zero = dz; zero_flag = zf;
        e = fetch_e;  e.zf = zf; push({nm, "/fetch"}, e);
        @(posedge clk); #1;
        e = decode_e; e.zf = zf; push({nm, "/decode"}, e);
        @(posedge clk); #1;
        e = ex; e.zf = zf; e.chk = 1'b1; e.word = instr; push({nm, "/exec"}, e);
        if (has_exc) begin
            @(posedge clk); #1;
            e = exc; e.zf = zf; push({nm, "/exc"}, e);
        end
        @(posedge clk); #1;
    endtask

    logic [9:0]  ctl_vec;
    logic [73:0] fld_act;
    logic [73:0] fld_exp;
    exp_t        mon_e;
    string       mon_n;
    assign ctl_vec = {reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, pc_write, pc_write_cond};
    assign fld_act = {opcode, rs, rt, rd, shamt, funct, immediate, address};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_tests++;
            if ({current_state, ctl_vec, alu_op, pc_source, alu_control, alu_overflow, alu_zero} !==
                {mon_e.st, mon_e.ctl, mon_e.aop, mon_e.psrc, mon_e.actl, mon_e.ovf, mon_e.zf}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d ctl=%b aop=%b psrc=%b actl=%b ovf=%b zf=%b, want st=%0d ctl=%b aop=%b psrc=%b actl=%b ovf=%b zf=%b",
                         mon_n, current_state, ctl_vec, alu_op, pc_source, alu_control, alu_overflow, alu_zero,
                         mon_e.st, mon_e.ctl, mon_e.aop, mon_e.psrc, mon_e.actl, mon_e.ovf, mon_e.zf);
            end
            if (mon_e.chk) begin
                n_tests++;
                fld_exp = {mon_e.word, mon_e.word[15:0], mon_e.word[25:0]};
                if (fld_act !== fld_exp) begin
                    n_fail++;
                    $display("FAIL %s/fields: got %h want %h", mon_n, fld_act, fld_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0; instruction = 32'h0; zero_flag = 1'b0; overflow = 1'b0; div_zero = 1'b0;
        #1;
        repeat (2) begin
            @(posedge clk); #1;
            push("reset", rst_e);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr("and",   32'h00221824, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b0000, 1'b0), 1'b0, none_e);
        run_instr("addi",  32'h2001000C, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0000001100, 2'b00, 2'b00, 4'b0010, 1'b0), 1'b0, none_e);
        run_instr("jr",    32'h03E00008, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0100000010, 2'b10, 2'b10, 4'b1111, 1'b0), 1'b0, none_e);
        run_instr("sra",   32'h00011043, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b1001, 1'b0), 1'b0, none_e);
        run_instr("sll",   32'h00000000, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b1000, 1'b0), 1'b0, none_e);
        run_instr("sub",   32'h00221822, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b0110, 1'b0), 1'b0, none_e);
        run_instr("slt",   32'h0022182A, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b0111, 1'b0), 1'b0, none_e);
        run_instr("lw",    32'h8C220004, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0001101100, 2'b00, 2'b00, 4'b0010, 1'b0), 1'b0, none_e);
        run_instr("sw",    32'hAC220004, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0000011000, 2'b00, 2'b00, 4'b0010, 1'b0), 1'b0, none_e);
        run_instr("beq",   32'h10220003, 1'b0, 1'b0, 1'b1, mk(5'd2, 10'b0010000001, 2'b01, 2'b01, 4'b0110, 1'b0), 1'b0, none_e);
        run_instr("j",     32'h08000010, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0100000010, 2'b00, 2'b10, 4'b1111, 1'b0), 1'b0, none_e);
        run_instr("xchg",  32'h00221005, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0000000100, 2'b10, 2'b00, 4'b1111, 1'b0), 1'b0, none_e);
        run_instr("mfhi",  32'h00001810, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b1111, 1'b0), 1'b0, none_e);
        run_instr("mult",  32'h00220018, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0000000000, 2'b10, 2'b00, 4'b1111, 1'b0), 1'b0, none_e);
        run_instr("badop", 32'hFC000000, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0000000000, 2'b00, 2'b00, 4'b1111, 1'b0), 1'b0, none_e);
        run_instr("badfn", 32'h0000003F, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b0000000000, 2'b10, 2'b00, 4'b1111, 1'b0), 1'b0, none_e);
        // Overflow on a non-arithmetic op must be ignored entirely.
        run_instr("and_ov", 32'h00221824, 1'b1, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b0000, 1'b0), 1'b0, none_e);
        run_instr("add_ov", 32'h00221820, 1'b1, 1'b0, 1'b0,
                  mk(5'd2, EXC_EN ? 10'b1000000000 : 10'b1000000100, 2'b10, 2'b00, 4'b0010, 1'b1), EXC_EN, exc_ovf_e);
        run_instr("addi_ov", 32'h2001000C, 1'b1, 1'b0, 1'b0,
                  mk(5'd2, EXC_EN ? 10'b0000001000 : 10'b0000001100, 2'b00, 2'b00, 4'b0010, 1'b1), EXC_EN, exc_ovf_e);
        run_instr("div_dz", 32'h0022001A, 1'b0, 1'b1, 1'b0, mk(5'd2, 10'b0000000000, 2'b10, 2'b00, 4'b1111, 1'b0), EXC_EN, exc_div_e);

        // Reset asserted during EXEC of a store aborts it immediately.
        instruction = 32'hAC220004; overflow = 1'b0; div_zero = 1'b0; zero_flag = 1'b0;
        push("abort/fetch", fetch_e);
        @(posedge clk); #1;
        push("abort/decode", decode_e);
        @(posedge clk); #1;
        reset = 1'b0;
        push("abort/reset0", rst_e);
        @(posedge clk); #1;
        push("abort/reset1", rst_e);
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr("post_rst", 32'h00221824, 1'b0, 1'b0, 1'b0, mk(5'd2, 10'b1000000100, 2'b10, 2'b00, 4'b0000, 1'b0), 1'b0, none_e);

        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk input 1, reset input 1; one clock; reset is asynchronous and active-low.
REQ-002 SHALL have inputs instruction 32 (current instruction word, held stable by the datapath), zero_flag 1 (ALU zero), overflow 1 (ALU overflow), div_zero 1 (divider divide-by-zero).
REQ-003 SHALL output the combinational field slices: opcode 6 [31:26], rs 5 [25:21], rt 5 [20:16], rd 5 [15:11], shamt 5 [10:6], funct 6 [5:0], immediate 16 [15:0], address 26 [25:0].
REQ-004 SHALL output alu_control 4, alu_zero 1 (=zero_flag), and alu_overflow 1 (=overflow AND current_state==EXEC AND instruction is add/sub/addi).
REQ-005 SHALL output these 1-bit controls: reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, pc_write, pc_write_cond.
REQ-006 SHALL output alu_op 2 (00 add, 01 sub, 10 funct-decoded), pc_source 2 (00 PC+4, 01 branch target, 10 jump/jr, 11 exception vector), and current_state 5.

Function
REQ-007 SHALL be a Moore FSM: registered state; all control outputs decoded combinationally from state, opcode and funct.
REQ-008 State encoding SHALL be FETCH=0, DECODE=1, EXEC=2, EXC_OVF=3, EXC_DIV=4; all other codes SHALL go to FETCH.
REQ-009 Normal sequence SHALL be FETCH->DECODE->EXEC->FETCH, so every instruction takes exactly 3 clocks.
REQ-010 FETCH SHALL assert mem_read=1, pc_write=1, pc_source=00, alu_op=00, and every other control 0.
REQ-011 DECODE SHALL assert all controls 0 except alu_op=00 (branch-target precompute).
REQ-012 In EXEC, R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, slt 0x2A, sll 0x00 or sra 0x03 SHALL give reg_dst=1, reg_write=1, alu_op=10.
REQ-013 In EXEC, mult 0x18 and div 0x1A SHALL assert no register write (HI/LO written by the datapath); mfhi 0x10 and mflo 0x12 SHALL give reg_dst=1, reg_write=1.
REQ-014 In EXEC, xchg 0x05 SHALL give reg_write=1 with reg_dst=0; the datapath performs the two-register swap.
REQ-015 In EXEC, jr 0x08 SHALL give pc_write=1, pc_source=10, jump=1.
REQ-016 In EXEC, addi 0x08 SHALL give alu_src=1, reg_write=1, reg_dst=0, alu_op=00.
REQ-017 In EXEC, lw 0x23 SHALL give alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1; sw 0x2B SHALL give alu_src=1, mem_write=1.
REQ-018 In EXEC, beq 0x04 SHALL give branch=1, pc_write_cond=1, alu_op=01, pc_source=01; j 0x02 SHALL give jump=1, pc_write=1, pc_source=10.
REQ-019 alu_control SHALL be: AND 0000, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRA 1001, and 1111 for none/pass.
REQ-020 An undefined opcode or funct SHALL execute as a NOP: EXEC with all write/memory/PC controls 0, then FETCH.

Reset
REQ-021 reset low SHALL immediately force current_state=FETCH, independent of clk.
REQ-022 While reset is low, all control outputs SHALL be 0 and alu_control=1111.
REQ-023 After reset is released, the first rising clk edge SHALL advance to DECODE.
REQ-024 reset asserted mid-instruction SHALL abort the instruction, and no further write strobes SHALL be issued.

Configuration
REQ-025 With CU_EXCEPTION_EN defined, overflow=1 in EXEC during add/sub/addi SHALL go to EXC_OVF, and div_zero=1 in EXEC during div SHALL go to EXC_DIV.
REQ-026 The EXC_OVF and EXC_DIV states SHALL last one cycle with pc_write=1, pc_source=11, reg_write=0, then go to FETCH.
REQ-027 In EXC_OVF and EXC_DIV, the EXEC reg_write SHALL be suppressed when the fault is present.
REQ-028 Without CU_EXCEPTION_EN, overflow and div_zero SHALL be ignored for sequencing, and states 3 and 4 SHALL be unreachable.

Verification
REQ-029 Reset low for 2 cycles, then released -> current_state 0,1,2,0 on successive edges; all controls 0 during reset.
REQ-030 instruction=0x00221824 (and $3,$1,$2) -> in EXEC: reg_dst=1, reg_write=1, alu_op=10, alu_control=0000, rs=1, rt=2, rd=3.
REQ-031 instruction=0x2001000C (addi $1,$0,12) -> in EXEC: alu_src=1, reg_write=1, reg_dst=0, immediate=0x000C, alu_control=0010.
REQ-032 instruction=0x03E00008 (jr $31) -> in EXEC: pc_write=1, pc_source=10, reg_write=0.
REQ-033 instruction=0x0022001A (div) with div_zero=1 and CU_EXCEPTION_EN defined -> state sequence 2->4->0 with pc_source=11 in state 4; without the macro -> 2->0.
REQ-034 instruction=0x00011043 (sra $2,$1,1) -> in EXEC: alu_control=1001, shamt=1; instruction=0x00000000 (sll nop) -> alu_control=1000.
